car_gate_ctrl: RTL and testbench

Clock-enable and reset-release sequencer for the two-domain clock/reset block. It generates the gating enables en1/en2 from per-domain clock requests. It limits inrush by letting only one domain be in its wake window at a time, gates idle domains off after a timeout, and holds domain-2 reset until its clock has run long enough. The block runs entirely in clk1 and sits between the power/clock manager and the clock-gating cells.

---
 rtl/car_gate_pkg.sv | 15 +
 rtl/car_gate_ctrl_if.sv | 24 ++
 rtl/car_gate_chan.sv | 90 +++++++++
 rtl/car_gate_ctrl.sv | 72 +++++++
 tb/tb_car_gate_ctrl.sv | 139 +++++++++++++
 5 files changed

// File: rtl/car_gate_pkg.sv
// Shared types and constants for the two-domain clock-enable / reset-release sequencer.
package car_gate_pkg;

    typedef enum logic [2:0] {OFF, PEND, WAKE, ON, IDLE} chan_state_e;

    localparam int CNT_W = 8;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/car_gate_ctrl_if.sv
// Request/enable bundle between the power/clock manager (master) and the gate sequencer (slave).
interface car_gate_ctrl_if;

    logic req1;
    logic req2;
    logic force_on;
    logic en1;
    logic en2;
    logic ack1;
    logic ack2;
    logic rst_n2_rel;
    logic busy;

    modport master (
        output req1, req2, force_on,
        input  en1, en2, ack1, ack2, rst_n2_rel, busy
    );

    modport slave (
        input  req1, req2, force_on,
        output en1, en2, ack1, ack2, rst_n2_rel, busy
    );

endinterface

// File: rtl/car_gate_chan.sv
// One gated clock channel: OFF/PEND/WAKE/ON/IDLE FSM with wake-settle and idle-timeout counters.
module car_gate_chan
    import car_gate_pkg::*;
#(
    parameter int CNT_W        = car_gate_pkg::CNT_W,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk1,
    input  logic             rst_n1,
    input  logic             r,
    input  logic             grant,
    input  logic [CNT_W-1:0] wake_len,
    output logic             en,
    output logic             ack,
    output logic             in_wake,
    output logic             pend
);

    localparam logic [CNT_W:0] IDLE_LIM = (CNT_W+1)'(IDLE_TIMEOUT);

    chan_state_e      state, state_nx;
    logic [CNT_W-1:0] wcnt, wcnt_nx, icnt, icnt_nx;
    logic             wake_done, idle_done;

    // Kept apart from the FSM process so the arbiter path has no apparent loop through grant.
    assign pend = r && (state == OFF || state == PEND);

    assign wake_done = ({1'b0, wcnt} + (CNT_W+1)'(1)) >= {1'b0, wake_len};
    // The ON cycle that saw r low plus this cycle are not in icnt, hence +2.
    assign idle_done = ({1'b0, icnt} + (CNT_W+1)'(2)) >= IDLE_LIM;

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        icnt_nx  = icnt;
        case (state)
            OFF, PEND: begin
                if (!r)
                    state_nx = OFF;
                else if (grant) begin
                    state_nx = WAKE;
                    wcnt_nx  = '0;
                end else
                    state_nx = PEND;
            end
            WAKE: begin
                if (wake_done) begin
                    state_nx = r ? ON : IDLE;
                    icnt_nx  = '0;
                end else if (wcnt != '1)
                    wcnt_nx = wcnt + CNT_W'(1);
            end
            ON: begin
                if (!r) begin
                    state_nx = IDLE;
                    icnt_nx  = '0;
                end
            end
            IDLE: begin
                if (r) begin
                    state_nx = ON;
                    icnt_nx  = '0;
                end else if (idle_done)
                    state_nx = OFF;
                else if (icnt != '1)
                    icnt_nx = icnt + CNT_W'(1);
            end
            default: state_nx = OFF;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n1) begin
        if (!rst_n1) begin
            state   <= OFF;
            wcnt    <= '0;
            icnt    <= '0;
            en      <= 1'b0;
            ack     <= 1'b0;
            in_wake <= 1'b0;
        end else begin
            state   <= state_nx;
            wcnt    <= wcnt_nx;
            icnt    <= icnt_nx;
            en      <= (state_nx == WAKE) || (state_nx == ON) || (state_nx == IDLE);
            ack     <= (state_nx == ON) || (state_nx == IDLE);
            in_wake <= (state_nx == WAKE);
        end
    end

endmodule

// File: rtl/car_gate_ctrl.sv
// Clock-enable and domain-2 reset-release sequencer: one wake slot shared round-robin by two channels.
module car_gate_ctrl
    import car_gate_pkg::*;
#(
    parameter int WAKE_DLY     = 4,
    parameter int IDLE_TIMEOUT = 16,
    parameter int RST_HOLD     = 8,
    parameter int CNT_W        = car_gate_pkg::CNT_W
) (
    input  logic            clk1,
    input  logic            rst_n1,
    car_gate_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAKE_LEN  = CNT_W'(WAKE_DLY);
    localparam logic [CNT_W-1:0] FIRST_LEN = CNT_W'(imax(WAKE_DLY, RST_HOLD));

    logic [1:0]            req2_sync;
    logic                  rr_ptr, rel_q, slot_free;
    logic [1:0]            r, grant, en, ack, in_wake, pend;
    logic [1:0][CNT_W-1:0] wake_len;

    assign r[CH1] = bus.req1 | bus.force_on;
    assign r[CH2] = req2_sync[1] | bus.force_on;

    // Contention resolved by the pointer; a lone requester takes the free slot directly.
    assign slot_free   = ~|in_wake;
    assign grant[CH1]  = slot_free & pend[CH1] & (~pend[CH2] | (rr_ptr == CH1));
    assign grant[CH2]  = slot_free & pend[CH2] & (~pend[CH1] | (rr_ptr == CH2));

    // Until domain-2 reset has been released once, its wake also covers the reset hold time.
    assign wake_len[CH1] = WAKE_LEN;
    assign wake_len[CH2] = bus.rst_n2_rel ? WAKE_LEN : FIRST_LEN;

    for (genvar i = 0; i < 2; i++) begin : g_ch
        car_gate_chan #(
            .CNT_W        (CNT_W),
            .IDLE_TIMEOUT (IDLE_TIMEOUT)
        ) u_chan (
            .clk1     (clk1),
            .rst_n1   (rst_n1),
            .r        (r[i]),
            .grant    (grant[i]),
            .wake_len (wake_len[i]),
            .en       (en[i]),
            .ack      (ack[i]),
            .in_wake  (in_wake[i]),
            .pend     (pend[i])
        );
    end

    always_ff @(posedge clk1 or negedge rst_n1) begin
        if (!rst_n1) begin
            req2_sync <= '0;
            rr_ptr    <= CH1;
            rel_q     <= 1'b0;
        end else begin
            req2_sync <= {req2_sync[0], bus.req2};
            rel_q     <= rel_q | ack[CH2];
            if (|grant)
                rr_ptr <= grant[CH1] ? CH2 : CH1;
        end
    end

    assign bus.en1        = en[CH1];
    assign bus.en2        = en[CH2];
    assign bus.ack1       = ack[CH1];
    assign bus.ack2       = ack[CH2];
    assign bus.rst_n2_rel = rel_q | ack[CH2];
    assign bus.busy       = |in_wake;

endmodule

// File: tb/tb_car_gate_ctrl.sv
// Directed bench for car_gate_ctrl; outs packs {en1,en2,ack1,ack2,rst_n2_rel,busy}.
module tb_car_gate_ctrl;

    logic clk1   = 1'b0;
    logic rst_n1 = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    car_gate_ctrl_if bus ();

    car_gate_ctrl #(
        .WAKE_DLY     (4),
        .IDLE_TIMEOUT (16),
        .RST_HOLD     (8),
        .CNT_W        (8)
    ) dut (
        .clk1   (clk1),
        .rst_n1 (rst_n1),
        .bus    (bus)
    );

    always #5 clk1 = ~clk1;

    logic [5:0] outs;
    assign outs = {bus.en1, bus.en2, bus.ack1, bus.ack2, bus.rst_n2_rel, bus.busy};

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        n_tests++;
        assert (outs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, outs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] exp);
        tick;
        chk(tag, exp);
    endtask

    task automatic step_n(input string tag, input int n, input logic [5:0] exp);
        for (int k = 1; k <= n; k++)
            step($sformatf("%s[%0d]", tag, k), exp);
    endtask

    initial begin
        bus.req1 = 1'b0; bus.req2 = 1'b0; bus.force_on = 1'b0;
        repeat (3) tick;
        chk("reset", 6'b000000);
        rst_n1 = 1'b1;
        tick;

        // ch1 wake: en1+busy cycles 1-4, ack1 at 5
        bus.req1 = 1'b1;
        step_n("w1", 4, 6'b100001);
        step("w1_ack", 6'b101000);

        // idle timeout: 16 low cycles then off
        bus.req1 = 1'b0;
        step_n("idle", 15, 6'b101000);
        step("idle_off", 6'b000000);

        // re-request at c+10 keeps ack and clears the idle count
        bus.req1 = 1'b1;
        step_n("rw", 4, 6'b100001);
        step("rw_ack", 6'b101000);
        bus.req1 = 1'b0;
        step_n("idle2", 10, 6'b101000);
        bus.req1 = 1'b1;
        step_n("reon", 10, 6'b101000);
        bus.req1 = 1'b0;
        step_n("idle3", 15, 6'b101000);
        step("idle3_off", 6'b000000);

        // simultaneous first wake
        rst_n1 = 1'b0;
        #1 chk("rst2", 6'b000000);
        tick; tick;
        rst_n1 = 1'b1;
        tick;
        bus.req2 = 1'b1;
        step_n("sync", 2, 6'b000000);
        bus.req1 = 1'b1;
        step_n("sim_w1", 4, 6'b100001);
        step("sim_ack1", 6'b101000);
        step_n("sim_w2", 8, 6'b111001);
        step("sim_ack2", 6'b111110);

        // both gated off, rst_n2_rel sticky, then second ch2 wake uses WAKE_DLY
        bus.req1 = 1'b0; bus.req2 = 1'b0;
        step_n("t4_idle", 15, 6'b111110);
        step_n("t4_ch1off", 2, 6'b010110);
        step("t4_ch2off", 6'b000010);
        bus.req2 = 1'b1;
        step_n("t4_sync", 2, 6'b000010);
        step_n("t4_wake", 4, 6'b010011);
        step("t4_ack", 6'b010110);

        // reset while ch2 is in a wake
        bus.req2 = 1'b0;
        step_n("t5_idle", 17, 6'b010110);
        step("t5_off", 6'b000010);
        bus.req2 = 1'b1;
        step_n("t5_sync", 2, 6'b000010);
        step_n("t5_wake", 2, 6'b010011);
        rst_n1 = 1'b0;
        #1 chk("t5_async_rst", 6'b000000);
        tick; tick;
        rst_n1 = 1'b1;
        step_n("t5_resync", 2, 6'b000000);
        step_n("t5_w8", 8, 6'b010001);
        step("t5_ack", 6'b010110);

        // force_on: round-robin wake, no timeout, then 16-cycle gate-off
        rst_n1 = 1'b0;
        bus.req2 = 1'b0;
        #1 chk("rst3", 6'b000000);
        tick;
        rst_n1 = 1'b1;
        tick;
        bus.force_on = 1'b1;
        step_n("f_w1", 4, 6'b100001);
        step("f_ack1", 6'b101000);
        step_n("f_w2", 8, 6'b111001);
        step("f_ack2", 6'b111110);
        step_n("f_hold", 110, 6'b111110);
        bus.force_on = 1'b0;
        step_n("f_idle", 15, 6'b111110);
        step("f_off", 6'b000010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
